// File: rtl/pc_npc_unit.sv
// Program counter and next-PC selection with run/halt tracking and a retired-instruction counter.
// Optional feature: define NPC_ALIGN_CHECK_EN to fault and halt on a misaligned JR/JALR target.
module pc_npc_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter bit          HALT_ON_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  NPCOp,
    input  logic [15:0] IMM16,
    input  logic [25:0] IMM26,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    input  logic        stall,
    output logic [31:0] PC,
    output logic [31:0] PCPLUS4,
    output logic        br_taken,
    output logic        halted,
    output logic [31:0] instret,
    output logic        fault
);

    // NPCOp encodings shared with ctrl_unit
    localparam logic [3:0] NPC_PLUS4       = 4'd0;
    localparam logic [3:0] NPC_BRANCH_BEQ  = 4'd1;
    localparam logic [3:0] NPC_BRANCH_BNE  = 4'd2;
    localparam logic [3:0] NPC_BRANCH_BGTZ = 4'd3;
    localparam logic [3:0] NPC_BRANCH_BLEZ = 4'd4;
    localparam logic [3:0] NPC_BRANCH_BLTZ = 4'd5;
    localparam logic [3:0] NPC_BRANCH_BGEZ = 4'd6;
    localparam logic [3:0] NPC_JUMP        = 4'd7;
    localparam logic [3:0] NPC_JUMPR       = 4'd8;
    localparam logic [3:0] NPC_NOP         = 4'd15;

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_instret;
    logic [31:0] w_pc4, w_br_tgt, w_npc;
    logic        w_redirect, w_is_nop, w_misalign, w_advance, w_run_go;

    assign w_pc4    = r_pc + 32'd4;
    assign w_br_tgt = w_pc4 + {{14{IMM16[15]}}, IMM16, 2'b00};
    assign w_is_nop = HALT_ON_NOP && (NPCOp == NPC_NOP);
    assign w_run_go = (r_state == S_RUN) && !stall;

`ifdef NPC_ALIGN_CHECK_EN
    assign w_misalign = (NPCOp == NPC_JUMPR) && (RD1[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_redirect = 1'b0;
        w_npc      = w_pc4;
        unique case (NPCOp)
            NPC_BRANCH_BEQ:  w_redirect = (RD1 == RD2);
            NPC_BRANCH_BNE:  w_redirect = (RD1 != RD2);
            NPC_BRANCH_BGTZ: w_redirect = !RD1[31] && (RD1 != 32'd0);
            NPC_BRANCH_BLEZ: w_redirect = RD1[31] || (RD1 == 32'd0);
            NPC_BRANCH_BLTZ: w_redirect = RD1[31];
            NPC_BRANCH_BGEZ: w_redirect = !RD1[31];
            NPC_JUMP: begin
                w_redirect = 1'b1;
                w_npc      = {w_pc4[31:28], IMM26, 2'b00};
            end
            NPC_JUMPR: begin
                w_redirect = 1'b1;
                w_npc      = {RD1[31:2], 2'b00};
            end
            default: ;
        endcase
        if (w_redirect && (NPCOp != NPC_JUMP) && (NPCOp != NPC_JUMPR))
            w_npc = w_br_tgt;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state (HALT is sticky until reset)
    always_comb begin
        w_state_nxt = r_state;
        if (w_run_go && (w_is_nop || w_misalign))
            w_state_nxt = S_HALT;
    end

    // FSM: outputs
    always_comb begin
        halted    = (r_state == S_HALT);
        br_taken  = (r_state == S_RUN) && w_redirect;
        w_advance = w_run_go && !w_is_nop && !w_misalign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_instret <= 32'd0;
        end else if (w_advance) begin
            r_pc      <= w_npc;
            r_instret <= r_instret + 32'd1;
        end
    end

`ifdef NPC_ALIGN_CHECK_EN
    logic r_fault;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_fault <= 1'b0;
        else if (w_run_go && w_misalign) r_fault <= 1'b1;
    end
    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign PC      = r_pc;
    assign PCPLUS4 = w_pc4;
    assign instret = r_instret;

endmodule
